// File: rtl/wave_analyzer_if.sv
// Sample stream and measurement bus between a waveform source and wave_analyzer.
// The slave modport is the analyzer; the master drives samples and control.
interface wave_analyzer_if #(
   parameter int DW = 5,
   parameter int CW = 8
);
   logic          sample_en;
   logic [DW-1:0] wave;
   logic          restart;
   logic [CW-1:0] period;
   logic [1:0]    wave_type;
   logic [DW-1:0] wmax;
   logic [DW-1:0] wmin;
   logic          meas_valid;
   logic          locked;

   modport master (
      output sample_en, wave, restart,
      input  period, wave_type, wmax, wmin, meas_valid, locked
   );

   modport slave (
      input  sample_en, wave, restart,
      output period, wave_type, wmax, wmin, meas_valid, locked
   );
endinterface

// File: rtl/wave_analyzer.sv
// Passive waveform analyzer: classifies square/sawtooth/triangle, measures period and lock.
// Per-period min/max tracking is built only when WAVE_ANALYZER_AMPL_EN is defined.
module wave_analyzer #(
   parameter int DW       = 5,
   parameter int CW       = 8,
   parameter int JUMP_TH  = 4,
   parameter int LOCK_CNT = 3
) (
   input  logic           clk,
   input  logic           rst,
   wave_analyzer_if.slave wa
);

   localparam int                MW         = $clog2(LOCK_CNT + 1);
   localparam logic [CW-1:0]     MAX_PERIOD = '1;
   localparam logic signed [DW:0] STEP_ONE  = (DW+1)'(1);
   localparam logic signed [DW:0] STEP_JTH  = (DW+1)'(JUMP_TH);
   localparam int F_FLAT = 0;
   localparam int F_UP1  = 1;
   localparam int F_DN1  = 2;
   localparam int F_JUP  = 3;
   localparam int F_JDN  = 4;
   localparam int F_OTH  = 5;

   typedef enum logic [1:0] {IDLE = 2'd0, ACQ = 2'd1, MEAS = 2'd2} state_t;

   state_t             state, next_state;
   logic [DW-1:0]      prev;
   logic               prev_dn1;
   logic [CW-1:0]      cnt;
   logic [5:0]         flags;
   logic [MW-1:0]      match_cnt;
   logic signed [DW:0] step;
   logic [5:0]         cur;
   logic               acc, anchor, open_win, grow_win, close_win, timeout;
   logic [1:0]         new_type;
   logic               match;

   logic [CW-1:0]      period_p1;
   logic [1:0]         wave_type_p1;
   logic [DW-1:0]      wmax_p1, wmin_p1;
   logic               vld_p1, locked_p1;

   function automatic logic [5:0] step_class(input logic signed [DW:0] dv);
      logic [5:0] c;
      c = '0;
      if (dv == '0)                c[F_FLAT] = 1'b1;
      else if (dv == STEP_ONE)     c[F_UP1]  = 1'b1;
      else if (dv == -STEP_ONE)    c[F_DN1]  = 1'b1;
      else if (dv >= STEP_JTH)     c[F_JUP]  = 1'b1;
      else if (dv <= -STEP_JTH)    c[F_JDN]  = 1'b1;
      else                         c[F_OTH]  = 1'b1;
      return c;
   endfunction

   function automatic logic [1:0] win_type(input logic [5:0] f);
      if (f[F_JUP] && f[F_JDN] && !f[F_UP1] && !f[F_DN1] && !f[F_OTH])
         return 2'd0;
      if (f[F_UP1] && f[F_JDN] && !f[F_DN1] && !f[F_JUP] && !f[F_FLAT] && !f[F_OTH])
         return 2'd1;
      if (f[F_UP1] && f[F_DN1] && !f[F_JUP] && !f[F_JDN] && !f[F_FLAT] && !f[F_OTH])
         return 2'd2;
      return 2'd3;
   endfunction

   // Stage 0: step classification of the incoming sample against the last accepted one
   assign acc      = wa.sample_en & ~wa.restart;
   assign step     = $signed({1'b0, wa.wave}) - $signed({1'b0, prev});
   assign cur      = step_class(step);
   assign anchor   = cur[F_JDN] | (cur[F_UP1] & prev_dn1);
   assign new_type = win_type(flags | cur);
   assign match    = (new_type != 2'd3) && (new_type == wave_type_p1) && (cnt == period_p1);

   always_ff @(posedge clk) begin
      if (rst || wa.restart) state <= IDLE;
      else                   state <= next_state;
   end

   always_comb begin
      next_state = state;
      open_win   = 1'b0;
      grow_win   = 1'b0;
      close_win  = 1'b0;
      timeout    = 1'b0;
      if (acc) begin
         unique case (state)
            IDLE: next_state = ACQ;
            ACQ: begin
               if (anchor) begin
                  open_win   = 1'b1;
                  next_state = MEAS;
               end
            end
            MEAS: begin
               if (anchor) begin
                  close_win = 1'b1;
                  open_win  = 1'b1;
               end else if (cnt == MAX_PERIOD) begin
                  timeout    = 1'b1;
                  next_state = ACQ;
               end else begin
                  grow_win = 1'b1;
               end
            end
            default: next_state = IDLE;
         endcase
      end
   end

   // The trough test needs the previous step; the first sample after IDLE has none.
   always_ff @(posedge clk) begin
      if (rst)      prev_dn1 <= 1'b0;
      else if (acc) prev_dn1 <= (state == IDLE) ? 1'b0 : cur[F_DN1];
   end

   always_ff @(posedge clk) begin
      if (acc) prev <= wa.wave;
      if (open_win) begin
         cnt   <= CW'(1);
         flags <= '0;
      end else if (grow_win) begin
         cnt   <= cnt + CW'(1);
         flags <= flags | cur;
      end
   end

   // Stage 1: measurement registers, valid pulse and lock tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         period_p1    <= '0;
         wave_type_p1 <= 2'd3;
         vld_p1       <= 1'b0;
         locked_p1    <= 1'b0;
         match_cnt    <= '0;
      end else begin
         vld_p1 <= close_win;
         if (wa.restart || timeout) begin
            locked_p1 <= 1'b0;
            match_cnt <= '0;
         end else if (close_win) begin
            period_p1    <= cnt;
            wave_type_p1 <= new_type;
            if (match) begin
               if (int'(match_cnt) < LOCK_CNT - 1)      match_cnt <= match_cnt + MW'(1);
               if (int'(match_cnt) + 1 >= LOCK_CNT - 1) locked_p1 <= 1'b1;
            end else begin
               match_cnt <= '0;
               locked_p1 <= 1'b0;
            end
         end
      end
   end

`ifdef WAVE_ANALYZER_AMPL_EN
   logic [DW-1:0] run_max, run_min;

   // A window opens on its anchor sample, so the running extremes start from it.
   always_ff @(posedge clk) begin
      if (open_win) begin
         run_max <= wa.wave;
         run_min <= wa.wave;
      end else if (grow_win) begin
         if (wa.wave > run_max) run_max <= wa.wave;
         if (wa.wave < run_min) run_min <= wa.wave;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wmax_p1 <= '0;
         wmin_p1 <= '0;
      end else if (close_win) begin
         wmax_p1 <= run_max;
         wmin_p1 <= run_min;
      end
   end
`else
   assign wmax_p1 = '0;
   assign wmin_p1 = '0;
`endif

   assign wa.period     = period_p1;
   assign wa.wave_type  = wave_type_p1;
   assign wa.wmax       = wmax_p1;
   assign wa.wmin       = wmin_p1;
   assign wa.meas_valid = vld_p1;
   assign wa.locked     = locked_p1;

endmodule

// File: tb/tb_wave_analyzer.sv
// Scoreboard bench for wave_analyzer: a window-level reference model predicts each
// measurement; a monitor pops and compares on every meas_valid pulse.
module tb_wave_analyzer;

   localparam int DW         = 5;
   localparam int CW         = 8;
   localparam int JUMP_TH    = 4;
   localparam int LOCK_CNT   = 3;
   localparam int MAX_PERIOD = (1 << CW) - 1;
   localparam int C_FLAT = 0, C_UP1 = 1, C_DN1 = 2, C_JUP = 3, C_JDN = 4, C_OTH = 5;
`ifdef WAVE_ANALYZER_AMPL_EN
   localparam bit AMPL = 1'b1;
`else
   localparam bit AMPL = 1'b0;
`endif

   typedef struct {
      int period;
      int wtype;
      int wmax;
      int wmin;
      int locked;
   } meas_t;

   logic clk = 1'b0;
   logic rst;

   wave_analyzer_if #(.DW(DW), .CW(CW)) wa ();

   wave_analyzer #(.DW(DW), .CW(CW), .JUMP_TH(JUMP_TH), .LOCK_CNT(LOCK_CNT)) dut (
      .clk (clk),
      .rst (rst),
      .wa  (wa)
   );

   always #5 clk = ~clk;

   int    checks = 0;
   int    errors = 0;
   int    n_meas = 0;
   meas_t exp_q[$];
   int    smp[$];
   int    last_anchor;
   int    m_type, m_period, m_match, m_locked;
   bit    gap_en;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int step_cat(input int a, input int b);
      int d;
      d = b - a;
      if (d == 0)         return C_FLAT;
      if (d == 1)         return C_UP1;
      if (d == -1)        return C_DN1;
      if (d >= JUMP_TH)   return C_JUP;
      if (d <= -JUMP_TH)  return C_JDN;
      return C_OTH;
   endfunction

   task automatic model_reset();
      smp.delete();
      last_anchor = -1;
      m_type      = 3;
      m_period    = 0;
      m_match     = 0;
      m_locked    = 0;
   endtask

   task automatic model_restart();
      smp.delete();
      last_anchor = -1;
      m_match     = 0;
      m_locked    = 0;
   endtask

   // Works on the whole sample history since the last restart: anchors are found by
   // looking back at the stored samples, and a window is analysed all at once when it closes.
   task automatic model_accept(input int w);
      int    k, c, per, t, mx, mn;
      bit    anchor;
      bit    has [6];
      meas_t e;
      smp.push_back(w);
      k = smp.size() - 1;
      if (k == 0) return;
      c = step_cat(smp[k-1], smp[k]);
      anchor = (c == C_JDN) ||
               (c == C_UP1 && k >= 2 && step_cat(smp[k-2], smp[k-1]) == C_DN1);
      if (last_anchor < 0) begin
         if (anchor) last_anchor = k;
      end else if (anchor) begin
         per = k - last_anchor;
         foreach (has[i]) has[i] = 1'b0;
         for (int j = last_anchor + 1; j <= k; j++) has[step_cat(smp[j-1], smp[j])] = 1'b1;
         mx = 0;
         mn = (1 << DW) - 1;
         for (int j = last_anchor; j < k; j++) begin
            if (smp[j] > mx) mx = smp[j];
            if (smp[j] < mn) mn = smp[j];
         end
         if (has[C_JUP] && has[C_JDN] && !has[C_UP1] && !has[C_DN1] && !has[C_OTH])
            t = 0;
         else if (has[C_UP1] && has[C_JDN] && !has[C_DN1] && !has[C_JUP] && !has[C_FLAT] && !has[C_OTH])
            t = 1;
         else if (has[C_UP1] && has[C_DN1] && !has[C_JUP] && !has[C_JDN] && !has[C_FLAT] && !has[C_OTH])
            t = 2;
         else
            t = 3;
         if (t != 3 && t == m_type && per == m_period) begin
            m_match++;
            if (m_match >= LOCK_CNT - 1) m_locked = 1;
         end else begin
            m_match  = 0;
            m_locked = 0;
         end
         m_type   = t;
         m_period = per;
         e.period = per;
         e.wtype  = t;
         e.wmax   = AMPL ? mx : 0;
         e.wmin   = AMPL ? mn : 0;
         e.locked = m_locked;
         exp_q.push_back(e);
         last_anchor = k;
      end else if (k - last_anchor == MAX_PERIOD) begin
         last_anchor = -1;
         m_match     = 0;
         m_locked    = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      wa.sample_en = 1'b0;
      repeat (n) tick();
   endtask

   task automatic send(input int w);
      int g;
      if (gap_en) begin
         g = $urandom_range(0, 2);
         for (int i = 0; i < g; i++) begin
            wa.sample_en = 1'b0;
            wa.wave      = DW'($urandom);
            tick();
         end
      end
      wa.sample_en = 1'b1;
      wa.wave      = w[DW-1:0];
      model_accept(w);
      tick();
      wa.sample_en = 1'b0;
   endtask

   task automatic send_square(input int lo, input int hi, input int half, input int n);
      for (int p = 0; p < n; p++) begin
         for (int i = 0; i < half; i++) send(lo);
         for (int i = 0; i < half; i++) send(hi);
      end
   endtask

   task automatic send_saw(input int lo, input int hi, input int n);
      for (int p = 0; p < n; p++)
         for (int v = lo; v <= hi; v++) send(v);
   endtask

   task automatic send_tri(input int lo, input int hi, input int n);
      for (int p = 0; p < n; p++) begin
         for (int v = lo; v <= hi; v++) send(v);
         for (int v = hi - 1; v > lo; v--) send(v);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_period"},     int'(wa.period),     0);
      chk({tag, "_wave_type"},  int'(wa.wave_type),  3);
      chk({tag, "_wmax"},       int'(wa.wmax),       0);
      chk({tag, "_wmin"},       int'(wa.wmin),       0);
      chk({tag, "_meas_valid"}, int'(wa.meas_valid), 0);
      chk({tag, "_locked"},     int'(wa.locked),     0);
   endtask

   always @(negedge clk) begin
      meas_t e;
      if (!rst && wa.meas_valid === 1'b1) begin
         n_meas++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_meas: got meas_valid=1 (period=%0d type=%0d), expected no measurement",
                     wa.period, wa.wave_type);
         end else begin
            e = exp_q.pop_front();
            chk("meas_period", int'(wa.period),    e.period);
            chk("meas_type",   int'(wa.wave_type), e.wtype);
            chk("meas_wmax",   int'(wa.wmax),      e.wmax);
            chk("meas_wmin",   int'(wa.wmin),      e.wmin);
            chk("meas_locked", int'(wa.locked),    e.locked);
         end
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: got no end of stimulus, expected completion within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int kind, lo, hi, n;
      rst          = 1'b1;
      wa.sample_en = 1'b0;
      wa.wave      = '0;
      wa.restart   = 1'b0;
      gap_en       = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check_reset("reset");

      for (int i = 0; i < 300; i++) send(7);
      idle(3);
      chk("const_no_meas", n_meas, 0);
      check_reset("const");

      send_square(0, 20, 10, 6);
      idle(3);
      chk("square_type",   int'(wa.wave_type), 0);
      chk("square_period", int'(wa.period),    20);
      chk("square_locked", int'(wa.locked),    1);
      chk("square_wmax",   int'(wa.wmax),      AMPL ? 20 : 0);
      chk("square_wmin",   int'(wa.wmin),      0);

      send_tri(0, 20, 6);
      idle(3);
      chk("tri_type",   int'(wa.wave_type), 2);
      chk("tri_period", int'(wa.period),    40);
      chk("tri_locked", int'(wa.locked),    1);

      gap_en = 1'b1;
      send_saw(0, 20, 6);
      idle(3);
      chk("saw_gap_type",   int'(wa.wave_type), 1);
      chk("saw_gap_period", int'(wa.period),    21);
      chk("saw_gap_locked", int'(wa.locked),    1);
      chk("saw_gap_wmax",   int'(wa.wmax),      AMPL ? 20 : 0);
      gap_en = 1'b0;

      for (int i = 0; i < 300; i++) send(0);
      idle(3);
      chk("timeout_locked", int'(wa.locked), 0);
      chk("timeout_period", int'(wa.period), 21);

      send_saw(0, 20, 6);
      idle(3);
      chk("resaw_locked", int'(wa.locked), 1);
      wa.restart = 1'b1;
      tick();
      wa.restart = 1'b0;
      model_restart();
      tick();
      chk("restart_locked", int'(wa.locked),    0);
      chk("restart_period", int'(wa.period),    21);
      chk("restart_type",   int'(wa.wave_type), 1);

      for (int s = 0; s < 12; s++) begin
         gap_en = $urandom_range(0, 1) == 1;
         kind   = $urandom_range(0, 3);
         lo     = $urandom_range(0, 10);
         hi     = lo + $urandom_range(JUMP_TH, 31 - lo);
         n      = $urandom_range(2, 4);
         case (kind)
            0:       send_square(lo, hi, $urandom_range(1, 12), n);
            1:       send_saw(lo, hi, n);
            2:       send_tri(lo, hi, n);
            default: for (int i = 0; i < 20 * n; i++) send($urandom_range(0, 31));
         endcase
      end
      gap_en = 1'b0;

      send_saw(0, 20, 3);
      send(0);
      send(1);
      send(2);
      idle(3);
      rst        = 1'b1;
      wa.restart = 1'b1;
      tick();
      rst        = 1'b0;
      wa.restart = 1'b0;
      model_reset();
      check_reset("rst_restart");

      send_square(3, 25, 6, 6);
      idle(4);
      chk("final_square_locked", int'(wa.locked), 1);
      chk("final_square_period", int'(wa.period), 12);

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
